// File: rtl/data_memory_delay_param.sv
// Parametrised slow main-memory model for the pipeline MEM stage.
// One outstanding transaction; separate read/write latencies, byte-enable
// writes, completion strobes, out-of-range detection and busy-drop flag.
module data_memory_delay_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int RAM_DEPTH  = 256,
    parameter int RD_LATENCY = 20,
    parameter int WR_LATENCY = 20
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rd_en,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] be,
    output logic                    ready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    rvalid,
    output logic                    wack,
    output logic                    err,
    output logic                    dropped
);

    localparam int BYTES   = DATA_WIDTH / 8;
    localparam int IDX_W   = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

    state_t state, state_next;

    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [BYTES-1:0]      be_q;
    logic                  oor_q;
    logic                  op_rd_q;

    logic [DATA_WIDTH-1:0] mem [0:RAM_DEPTH-1] = '{default: '0};

    logic request;
    logic accept;
    logic rd_finish;
    logic wr_finish;

    assign request   = rd_en | wr_en;
    assign accept    = ready & request;
    assign rd_finish = (state == RD_WAIT) && (cnt == '0);
    assign wr_finish = (state == WR_WAIT) && (cnt == '0);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic; a write wins over a simultaneous read
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (wr_en)
                    state_next = WR_WAIT;
                else if (rd_en)
                    state_next = RD_WAIT;
                else
                    state_next = IDLE;
            end
            RD_WAIT: if (cnt == '0) state_next = DONE;
            WR_WAIT: if (cnt == '0) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode; DONE is ready so back-to-back requests are accepted
    always_comb begin
        ready  = (state == IDLE) || (state == DONE);
        rvalid = (state == DONE) && op_rd_q;
        wack   = (state == DONE) && !op_rd_q;
        err    = (state == DONE) && oor_q;
    end

    // Request latches, latency counter, read data and busy-drop flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            oor_q   <= 1'b0;
            op_rd_q <= 1'b0;
            rdata   <= '0;
            dropped <= 1'b0;
        end else begin
            dropped <= request & ~ready;
            if (accept) begin
                idx_q   <= addr[IDX_W-1:0];
                wdata_q <= wdata;
                be_q    <= be;
                oor_q   <= (addr >= ADDR_WIDTH'(RAM_DEPTH));
                op_rd_q <= ~wr_en;
                cnt     <= wr_en ? CNT_W'(WR_LATENCY - 1) : CNT_W'(RD_LATENCY - 1);
            end else if ((state == RD_WAIT || state == WR_WAIT) && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (rd_finish)
                rdata <= oor_q ? '0 : mem[idx_q];
        end
    end

    // Memory array commit on the edge entering DONE; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_finish && !oor_q) begin
            for (int unsigned i = 0; i < BYTES; i++) begin
                if (be_q[i])
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_memory_delay_param.sv
// Bench for data_memory_delay_param: a transaction-level model predicts every
// output cycle by cycle for the default instance; a second instance with
// unit latencies is checked with literal expectations.
module tb_data_memory_delay_param;

    localparam int LAT = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd_en = 1'b0, wr_en = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  be = '0;
    logic        ready, rvalid, wack, err, dropped;
    logic [31:0] rdata;

    logic        f_rd = 1'b0, f_wr = 1'b0;
    logic [31:0] f_addr = '0, f_wdata = '0;
    logic [3:0]  f_be = '0;
    logic        f_ready, f_rvalid, f_wack, f_err, f_dropped;
    logic [31:0] f_rdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_memory_delay_param u_dut (
        .clk(clk), .reset(reset), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
        .wdata(wdata), .be(be), .ready(ready), .rdata(rdata), .rvalid(rvalid),
        .wack(wack), .err(err), .dropped(dropped)
    );

    data_memory_delay_param #(.RD_LATENCY(1), .WR_LATENCY(1)) u_fast (
        .clk(clk), .reset(reset), .rd_en(f_rd), .wr_en(f_wr), .addr(f_addr),
        .wdata(f_wdata), .be(f_be), .ready(f_ready), .rdata(f_rdata), .rvalid(f_rvalid),
        .wack(f_wack), .err(f_err), .dropped(f_dropped)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: each accepted request completes at acceptance edge + LAT
    logic [31:0] mmem [256];
    bit          m_pend = 0, m_rd = 0, m_oor = 0, m_ready = 1;
    logic [31:0] m_addr = '0, m_wd = '0;
    logic [3:0]  m_be = '0;
    int          cyc = 0, m_comp = 0;
    bit          exp_rvalid = 0, exp_wack = 0, exp_err = 0, exp_drop = 0;
    logic [31:0] exp_rdata = '0;

    initial for (int i = 0; i < 256; i++) mmem[i] = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pend = 0; m_ready = 1;
            exp_rvalid = 0; exp_wack = 0; exp_err = 0; exp_drop = 0;
            exp_rdata = '0;
        end else begin
            cyc++;
            exp_rvalid = 0; exp_wack = 0; exp_err = 0;
            exp_drop = (rd_en || wr_en) && !m_ready;
            if (m_ready && (rd_en || wr_en)) begin
                m_pend = 1; m_rd = !wr_en; m_addr = addr; m_wd = wdata; m_be = be;
                m_oor = (addr >= 256); m_comp = cyc + LAT;
            end else if (m_pend && cyc == m_comp) begin
                m_pend = 0;
                exp_err = m_oor;
                if (m_rd) begin
                    exp_rvalid = 1;
                    exp_rdata = m_oor ? 32'h0 : mmem[m_addr[7:0]];
                end else begin
                    exp_wack = 1;
                    if (!m_oor)
                        for (int b = 0; b < 4; b++)
                            if (m_be[b]) mmem[m_addr[7:0]][8*b +: 8] = m_wd[8*b +: 8];
                end
            end
            m_ready = !m_pend;
        end
    end

    bit started = 0;
    int drop_cnt = 0, wack_cnt = 0;

    // Per-cycle compare of the default instance against the model
    always @(negedge clk) begin
        if (started && !reset) begin
            check("ready", 32'(ready), 32'(m_ready));
            check("rvalid", 32'(rvalid), 32'(exp_rvalid));
            check("wack", 32'(wack), 32'(exp_wack));
            check("err", 32'(err), 32'(exp_err));
            check("dropped", 32'(dropped), 32'(exp_drop));
            check("rdata", rdata, exp_rdata);
            if (dropped) drop_cnt++;
            if (wack) wack_cnt++;
        end
    end

    int acc = 0;

    // Called at posedge+2; holds the request across exactly one edge
    task automatic issue(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b);
        rd_en = rd; wr_en = wr; addr = a; wdata = d; be = b;
        @(posedge clk); #2;
        acc = cyc;
        rd_en = 0; wr_en = 0;
    endtask

    task automatic wait_done(input string name, output int lat, output bit got_r,
                             output bit got_err, output logic [31:0] data);
        bit seen = 0;
        lat = -1; got_r = 0; got_err = 0; data = '0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            if (rvalid || wack) begin
                seen = 1; lat = cyc - acc; got_r = rvalid; got_err = err; data = rdata;
            end
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL %s_timeout actual=none expected=completion", name);
        end
        @(posedge clk); #2;
    endtask

    task automatic do_write(input string name, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] b, output bit e);
        int l; bit r; logic [31:0] x;
        issue(0, 1, a, d, b);
        wait_done(name, l, r, e, x);
        check({name, "_lat"}, 32'(l), 32'd20);
    endtask

    task automatic do_read(input string name, input logic [31:0] a,
                           output logic [31:0] d, output bit e);
        int l; bit r;
        issue(1, 0, a, '0, '0);
        wait_done(name, l, r, e, d);
        check({name, "_lat"}, 32'(l), 32'd20);
        check({name, "_isread"}, 32'(r), 32'd1);
    endtask

    initial begin
        logic [31:0] d;
        bit e, r;
        int l, d0, w0;

        // 1. reset
        repeat (2) @(posedge clk);
        #2 reset = 0;
        started = 1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_rdata", rdata, 32'h0);
        check("rst_pulses", {28'h0, rvalid, wack, err, dropped}, 32'h0);

        // 2. round trip
        do_write("wr17", 32'd17, 32'h00000ABC, 4'hF, e);
        do_read("rd17", 32'd17, d, e);
        check("rd17_data", d, 32'h00000ABC);
        repeat (3) @(posedge clk); #2;
        check("rd17_hold", rdata, 32'h00000ABC);

        // 3. byte enables
        do_write("wr5a", 32'd5, 32'h11223344, 4'hF, e);
        do_write("wr5b", 32'd5, 32'hAABBCCDD, 4'b0101, e);
        check("be_hold_rdata", rdata, 32'h00000ABC);
        do_read("rd5", 32'd5, d, e);
        check("rd5_data", d, 32'h11BB33DD);

        // 4. out of range
        do_write("wr300", 32'd300, 32'hDEADBEEF, 4'hF, e);
        check("wr300_err", 32'(e), 32'd1);
        do_read("rd300", 32'd300, d, e);
        check("rd300_err", 32'(e), 32'd1);
        check("rd300_data", d, 32'h0);
        do_read("rd44", 32'd44, d, e);
        check("rd44_err", 32'(e), 32'd0);
        check("rd44_data", d, 32'h0);

        // 5. busy drops, then simultaneous request
        d0 = drop_cnt;
        issue(0, 1, 32'd7, 32'h77, 4'hF);
        rd_en = 1; addr = 32'd17;
        repeat (3) begin @(posedge clk); #2; end
        rd_en = 0;
        wait_done("busy", l, r, e, d);
        check("busy_lat", 32'(l), 32'd20);
        check("busy_isread", 32'(r), 32'd0);
        check("busy_drops", 32'(drop_cnt - d0), 32'd3);
        issue(1, 1, 32'd20, 32'h55, 4'hF);
        wait_done("both", l, r, e, d);
        check("both_isread", 32'(r), 32'd0);
        check("both_lat", 32'(l), 32'd20);
        do_read("rd20", 32'd20, d, e);
        check("rd20_data", d, 32'h55);

        // 6a. reset mid-write
        do_write("wr9", 32'd9, 32'h99, 4'hF, e);
        w0 = wack_cnt;
        issue(0, 1, 32'd9, 32'h1234, 4'hF);
        repeat (4) @(posedge clk);
        #3 reset = 1;
        repeat (2) @(posedge clk);
        #2 reset = 0;
        check("rst_mid_ready", 32'(ready), 32'd1);
        repeat (30) @(posedge clk); #2;
        check("rst_mid_nowack", 32'(wack_cnt - w0), 32'd0);
        do_read("rd9", 32'd9, d, e);
        check("rd9_data", d, 32'h99);

        // 6b. unit latency, back-to-back write then read
        f_wr = 1; f_addr = 32'd3; f_wdata = 32'hCAFEF00D; f_be = 4'hF;
        @(posedge clk); #2;
        f_wr = 0;
        check("fast_busy", 32'(f_ready), 32'd0);
        @(posedge clk); #2;
        check("fast_wack", 32'(f_wack), 32'd1);
        check("fast_done_ready", 32'(f_ready), 32'd1);
        f_rd = 1;
        @(posedge clk); #2;
        f_rd = 0;
        check("fast_gap", {30'h0, f_wack, f_rvalid}, 32'h0);
        @(posedge clk); #2;
        check("fast_rvalid", 32'(f_rvalid), 32'd1);
        check("fast_rdata", f_rdata, 32'hCAFEF00D);
        check("fast_err", 32'(f_err), 32'd0);
        @(posedge clk); #2;
        check("fast_idle", {30'h0, f_rvalid, f_dropped}, 32'h0);

        started = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_memory_delay_param.md
Name: data_memory_delay_param

Overview:
- Parametrised successor of the fixed-latency data memory model; sits on the pipeline MEM-stage port and models slow main memory.
- Configurable data width, depth, and separate read/write latencies.
- Adds byte-enable writes, a completion strobe for reads and writes, out-of-range detection, and a drop flag for requests made while busy.
- Handles one outstanding transaction at a time.

Parameters:
- DATA_WIDTH, 32, data bus width in bits; must be a multiple of 8.
- ADDR_WIDTH, 32, address bus width (word address).
- RAM_DEPTH, 256, number of DATA_WIDTH-bit words.
- RD_LATENCY, 20, cycles from read acceptance to rvalid; minimum 1.
- WR_LATENCY, 20, cycles from write acceptance to wack; minimum 1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- rd_en  in  1  read request; sampled only while ready=1.
- wr_en  in  1  write request; sampled only while ready=1.
- addr  in  ADDR_WIDTH  word address.
- wdata  in  DATA_WIDTH  write data.
- be  in  DATA_WIDTH/8  byte enables; bit i controls byte lane i.
- ready  out  1  idle; a request can be accepted.
- rdata  out  DATA_WIDTH  read data; valid when rvalid=1, then held.
- rvalid  out  1  one-cycle read-completion pulse.
- wack  out  1  one-cycle write-completion pulse.
- err  out  1  one-cycle pulse alongside rvalid/wack when the address was out of range.
- dropped  out  1  one-cycle pulse, the cycle after rd_en or wr_en was high while ready=0.

Behaviour:
Reset:
- Asynchronous, active-high; takes effect immediately.
- Outputs after reset: ready=1, rdata=0, rvalid=0, wack=0, err=0, dropped=0.
- FSM goes to IDLE, latency counter clears to 0, latched request registers clear.
- Memory array contents are not reset; the array is zero-initialised at time 0.

States:
- IDLE: ready=1.
  - On an edge with wr_en=1, latch addr, wdata and be, load counter with WR_LATENCY-1, go to WR_WAIT.
  - On an edge with rd_en=1 and wr_en=0, latch addr, load counter with RD_LATENCY-1, go to RD_WAIT.
  - If both are high, the write wins and the read is discarded silently (no dropped pulse).
- RD_WAIT / WR_WAIT: ready=0.
  - The counter decrements each edge.
  - On the edge where counter==0, go to DONE.
- DONE: lasts one cycle.
  - For a read: rvalid=1, and rdata = mem[latched addr], updated on the entry edge.
  - For a write: wack=1; the array write commits on the entry edge.
  - ready=1 in DONE, so a new request can be accepted on the edge that leaves DONE (back-to-back operation).
  - With no new request, go to IDLE.

Latency:
- If a request is sampled at edge k, the completion pulse is high for exactly the cycle between edges k+LAT and k+LAT+1.
- With LAT=1, the pulse appears in the cycle right after acceptance.

Write rules:
- Only lanes with be[i]=1 are updated; other bytes keep their value.
- be all zero: still completes with wack, memory unchanged.

Address range:
- addr >= RAM_DEPTH: full latency is still honoured, err=1 with the completion pulse.
- Out-of-range write: suppressed.
- Out-of-range read: returns rdata=0.
- No aliasing or wrap-around.

Ordering and hold:
- A read accepted after a write's wack returns the written data; no forwarding is needed, because only one transaction is outstanding.
- rdata holds its last value through writes and idle cycles; only a read completion or reset changes it.

Busy requests:
- rd_en or wr_en while ready=0 is ignored: no state change, dropped pulses the next cycle.
- dropped re-pulses every cycle the request persists.

Reset mid-operation:
- The pending transaction is abandoned: no completion pulse, and a pending write is not committed.

Test Plan:
1. Reset behaviour: assert reset for 2 cycles, then release -> ready=1, rdata=0, rvalid=wack=err=dropped=0.
2. Write/read round trip (defaults): write addr=17, wdata=0x00000ABC, be=4'hF; wait for wack; read addr=17.
   - wack appears exactly 20 cycles after acceptance.
   - rvalid appears 20 cycles after read acceptance, with rdata=0x00000ABC, held afterwards.
3. Byte enables: write 0x11223344 to addr 5 (be=F), then write 0xAABBCCDD with be=4'b0101, then read addr 5 -> rdata=0x11BB33DD.
4. Out of range: write to addr=300 (RAM_DEPTH=256), then read addr=300 -> err pulses with both wack and rvalid; rdata=0.
   - Reading addr 300 mod 256 = 44 is unchanged.
5. Busy and simultaneous requests:
   - Raise rd_en for 3 cycles in mid-write -> dropped pulses 3 times; only the write completes.
   - Assert rd_en and wr_en together in IDLE -> only the write executes (wack, no rvalid).
6. Reset and minimum latency:
   - Reset asserted asynchronously 5 cycles into a write to addr 9 -> no wack; a later read of addr 9 returns the old value.
   - RD_LATENCY=WR_LATENCY=1 instance, back-to-back write then read issued in the DONE cycle -> pulses 1 cycle apart, correct data.
